ixayoi_axil_master: RTL and testbench
=====================================

Name: ixayoi_axil_master

Overview:
- Parametrised AXI4-Lite master port for the ixayoi core. Successor to the fixed 32-bit, single-transaction memory ports.
- Converts the core's valid/ready request/response stream into AXI4-Lite AW/W/B/AR/R traffic.
- Configurable address width, data width and outstanding depth. AW and W issue independently. Responses return in order.
- One instance is used per core memory port (instruction: reads only; data: reads and writes).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 or 64 are legal (elaboration error otherwise).
- MAX_OUT, 4, maximum accepted-but-unanswered requests; power of two, 1..16.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid / req_ready  in / out  1  core request handshake.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address, passed to AXI unmodified.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid / rsp_ready  out / in  1  core response handshake.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  response code was SLVERR or DECERR.
- rsp_we  out  1  response belongs to a write.
- m_axi_aw{addr,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{valid,ready,resp}, m_axi_ar{addr,valid,ready}, m_axi_r{valid,ready,data,resp}: standard AXI4-Lite master signals. Widths are ADDR_W, DATA_W, DATA_W/8, and 2 for resp fields.

Behaviour:
- Reset values (all asynchronous on reset):
  - awvalid, wvalid, arvalid, bready, rready, rsp_valid = 0.
  - Address and data outputs = 0.
  - pend = 0, issued = 0, mode = read, slot empty.
  - req_ready is 1 in the first cycle after reset deasserts.
- Reset mid-transfer: all state is cleared and in-flight AXI transactions are abandoned. The interconnect must be reset together with this block.
- Issue slot: holds one request.
  - On req fire the slot is loaded. The next cycle drives arvalid (read), or awvalid and wvalid together (write). Latency from req fire to AXI valid is 1 cycle.
  - awvalid and wvalid each drop on their own handshake.
  - A write slot completes when both AW and W have fired, in either order or in the same cycle. A read slot completes on AR fire.
- Counters:
  - pend counts accepted requests whose response has not yet been delivered. It is incremented on req fire and decremented on rsp fire; both in the same cycle leaves it unchanged.
  - issued counts slots that completed whose response has not yet been delivered.
  - Both counters are $clog2(MAX_OUT+1) bits wide.
- req_ready = (slot empty OR slot completes this cycle) AND pend < MAX_OUT AND (pend == 0 OR req_we == mode).
  - The combinational path from arready/awready/wready to req_ready is intentional; it sustains 1 request per cycle.
- mode is loaded from req_we on req fire when pend == 0. Reads and writes are never outstanding at the same time, which guarantees in-order responses.
- Responses:
  - rready = rsp_ready AND mode == read AND issued > 0.
  - bready = rsp_ready AND mode == write AND issued > 0.
  - rsp_valid = (mode ? bvalid : rvalid) AND issued > 0.
  - rsp_err = resp[1]. rsp_we = mode. The response path is combinational (zero added latency).
- Boundaries:
  - pend == MAX_OUT: req_ready = 0, even if rsp fires in the same cycle.
  - A type switch stalls until pend == 0.
  - A response arriving in the same cycle its slot completes is not accepted until the following cycle (issued has not yet incremented).

Optional Feature:
- Macro IXAYOI_AXIL_PERF_EN.
- When defined, adds two outputs:
  - perf_txn (64 bits): increments on every rsp fire.
  - perf_stall (32 bits): increments on every cycle with req_valid AND NOT req_ready.
  - Both counters reset to 0 and wrap silently.
- When not defined, these ports and counters do not exist.

Decomposition:
- Package ixayoi_axil_pkg contains:
  - Response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11.
  - Enum mode_t {MODE_READ, MODE_WRITE}.
  - Function cnt_w(n) = $clog2(n+1).
- One sub-module, ixayoi_axil_issue: the issue slot with the AW/W/AR valid flags and its completion pulse.

Test Plan:
- Single read: after reset, req read addr 0x100. Expect arvalid 1 cycle after fire with araddr = 0x100. Slave returns rdata 0xDEADBEEF, OKAY. Expect rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_we = 0.
- Split write: awready is held low for 3 cycles while wready is high. Expect wvalid to drop after 1 cycle, awvalid to hold until AW fires, and req_ready to stay low until AW fires. Slave returns bresp SLVERR. Expect rsp_err = 1, rsp_we = 1.
- Depth limit: MAX_OUT = 4, 5 back-to-back reads, slave never returns R. Expect exactly 4 AR fires and req_ready = 0 from then on. Releasing one R restores req_ready the following cycle.
- Mode switch: 2 reads outstanding, then a write is requested. Expect req_ready = 0 until both R responses are delivered, then AW/W issue.
- Async reset: assert reset mid-write while awvalid = 1. Expect all valid outputs to be 0 immediately, without a clock edge, and pend = 0.
- DATA_W = 64: write wstrb 0xF0, wdata 0x1122334455667788. Expect these to appear unchanged on m_axi_wstrb and m_axi_wdata. With PERF_EN defined, expect perf_txn = 1 after the response is delivered.

Source files
------------

// File: rtl/ixayoi_axil_pkg.sv
// Shared types and constants for the ixayoi AXI4-Lite master port.
// Response codes, transfer direction and counter sizing helper.
package ixayoi_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ixayoi_axil_issue.sv
// Single-entry issue slot: holds one request and drives AW/W or AR until each handshakes.
// o_done_c pulses in the cycle the last outstanding address/data channel fires.
module ixayoi_axil_issue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [DATA_W/8-1:0]   i_wstrb,
  input  logic                  i_awready,
  input  logic                  i_wready,
  input  logic                  i_arready,
  output logic                  o_awvalid,
  output logic                  o_wvalid,
  output logic                  o_arvalid,
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic [ADDR_W-1:0]     o_araddr,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  output logic                  o_busy_c,
  output logic                  o_done_c
);

  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_arvalid;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [ADDR_W-1:0]   r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;

  logic                w_awvalid_nxt;
  logic                w_wvalid_nxt;
  logic                w_arvalid_nxt;

  // The slot is occupied exactly while any of its channels still has to handshake.
  assign o_busy_c = r_awvalid | r_wvalid | r_arvalid;
  assign o_done_c = o_busy_c
                  & (~r_awvalid | i_awready)
                  & (~r_wvalid  | i_wready)
                  & (~r_arvalid | i_arready);

  // Each valid drops on its own handshake; a load (only allowed when empty or completing) re-arms.
  always_comb begin
    w_awvalid_nxt = r_awvalid & ~i_awready;
    w_wvalid_nxt  = r_wvalid  & ~i_wready;
    w_arvalid_nxt = r_arvalid & ~i_arready;
    if (i_load) begin
      w_awvalid_nxt = i_we;
      w_wvalid_nxt  = i_we;
      w_arvalid_nxt = ~i_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_arvalid <= w_arvalid_nxt;
    end
  end

  // Payload registers only change on load, so they stay stable while valid is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awaddr <= '0;
      r_araddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (i_load) begin
      if (i_we) begin
        r_awaddr <= i_addr;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end else begin
        r_araddr <= i_addr;
      end
    end
  end

  assign o_awvalid = r_awvalid;
  assign o_wvalid  = r_wvalid;
  assign o_arvalid = r_arvalid;
  assign o_awaddr  = r_awaddr;
  assign o_araddr  = r_araddr;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;

endmodule

// File: rtl/ixayoi_axil_master.sv
// AXI4-Lite master port: core valid/ready requests in, in-order responses out.
// Define IXAYOI_AXIL_PERF_EN to add the perf_txn / perf_stall counters.
module ixayoi_axil_master
  import ixayoi_axil_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef IXAYOI_AXIL_PERF_EN
  output logic [63:0]           perf_txn,
  output logic [31:0]           perf_stall,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_we,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp
);

  localparam int unsigned CNT_W = cnt_w(MAX_OUT);

  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
    $error("ixayoi_axil_master: DATA_W must be 32 or 64");
  end
  if ((MAX_OUT < 1) || (MAX_OUT > 16) || ((MAX_OUT & (MAX_OUT - 1)) != 0)) begin : g_bad_max_out
    $error("ixayoi_axil_master: MAX_OUT must be a power of two in 1..16");
  end

  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] r_issued;
  mode_t            r_mode;

  logic w_busy;
  logic w_done;
  logic w_pend_zero;
  logic w_issued_nz;
  logic w_mode_ok;
  logic w_req_fire;
  logic w_rsp_fire;
  logic w_unused;

  ixayoi_axil_issue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_issue (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_req_fire),
    .i_we      (req_we),
    .i_addr    (req_addr),
    .i_wdata   (req_wdata),
    .i_wstrb   (req_wstrb),
    .i_awready (m_axi_awready),
    .i_wready  (m_axi_wready),
    .i_arready (m_axi_arready),
    .o_awvalid (m_axi_awvalid),
    .o_wvalid  (m_axi_wvalid),
    .o_arvalid (m_axi_arvalid),
    .o_awaddr  (m_axi_awaddr),
    .o_araddr  (m_axi_araddr),
    .o_wdata   (m_axi_wdata),
    .o_wstrb   (m_axi_wstrb),
    .o_busy_c  (w_busy),
    .o_done_c  (w_done)
  );

  assign w_pend_zero = (r_pend == '0);
  assign w_issued_nz = (r_issued != '0);
  // Direction may only change once everything is drained, which keeps responses in order.
  assign w_mode_ok   = w_pend_zero | (mode_t'(req_we) == r_mode);

  // Ready looks through the slot's completion so back-to-back requests sustain one per cycle.
  assign req_ready  = (~w_busy | w_done) & (r_pend < CNT_W'(MAX_OUT)) & w_mode_ok;
  assign w_req_fire = req_valid & req_ready;

  assign m_axi_rready = rsp_ready & (r_mode == MODE_READ)  & w_issued_nz;
  assign m_axi_bready = rsp_ready & (r_mode == MODE_WRITE) & w_issued_nz;

  assign rsp_valid  = ((r_mode == MODE_WRITE) ? m_axi_bvalid : m_axi_rvalid) & w_issued_nz;
  assign w_rsp_fire = rsp_valid & rsp_ready;
  assign rsp_rdata  = (r_mode == MODE_READ) ? m_axi_rdata : '0;
  assign rsp_err    = (r_mode == MODE_WRITE) ? m_axi_bresp[1] : m_axi_rresp[1];
  assign rsp_we     = (r_mode == MODE_WRITE);

  // Low response bits do not distinguish OKAY from EXOKAY or SLVERR from DECERR here.
  assign w_unused = m_axi_bresp[0] ^ m_axi_rresp[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend   <= '0;
      r_issued <= '0;
      r_mode   <= MODE_READ;
    end else begin
      r_pend   <= r_pend + CNT_W'(w_req_fire) - CNT_W'(w_rsp_fire);
      r_issued <= r_issued + CNT_W'(w_done) - CNT_W'(w_rsp_fire);
      if (w_req_fire && w_pend_zero) begin
        r_mode <= mode_t'(req_we);
      end
    end
  end

`ifdef IXAYOI_AXIL_PERF_EN
  logic [63:0] r_perf_txn;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_txn   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_rsp_fire) begin
        r_perf_txn <= r_perf_txn + 64'd1;
      end
      if (req_valid && !req_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_txn   = r_perf_txn;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_ixayoi_axil_master.sv
// Bench for ixayoi_axil_master (DATA_W=64, MAX_OUT=4): directed scenarios, then
// random core/slave traffic against an in-order transaction scoreboard.
module tb_ixayoi_axil_master;
  import ixayoi_axil_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned MO = 4;

  logic          clk;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
`ifdef IXAYOI_AXIL_PERF_EN
  logic [63:0]   perf_txn;
  logic [31:0]   perf_stall;
`endif

  ixayoi_axil_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset),
`ifdef IXAYOI_AXIL_PERF_EN
    .perf_txn(perf_txn), .perf_stall(perf_stall),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_we(rsp_we),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = RESP_OKAY;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = RESP_OKAY;
  endtask

  // Scoreboard payloads.
  typedef struct packed { logic [AW-1:0] addr; logic [1:0] resp; logic [DW-1:0] data; } rd_t;
  typedef struct packed { logic [DW-1:0] data; logic [SW-1:0] strb; } wd_t;
  typedef struct packed { logic we; logic err; logic [DW-1:0] data; } rsp_t;

  rd_t           exp_ar_q[$];
  rd_t           r_q[$];
  logic [AW-1:0] exp_aw_q[$];
  wd_t           exp_w_q[$];
  logic [1:0]    wr_resp_q[$];
  logic [1:0]    b_q[$];
  rsp_t          exp_rsp_q[$];

  int   m_pend, m_acc, m_dlv, m_ar, m_aw, m_w, m_b, issued, done_after;
  logic m_mode, cur_we;
  logic ar_f, aw_f, w_f, r_f, b_f, req_f, rsp_f, r_prev, b_prev, req_prev, exp_rdy, gen;
  logic [1:0]    rresp_n;
  logic [DW-1:0] rdata_n;
  rd_t  rd_e;
  wd_t  wd_e;
  rsp_t rs_e;
  int   nacc, nar, nrsp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0;
    idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 64'(0));
    check("rst_readies", 64'({m_axi_bready, m_axi_rready}), 64'(0));
    check("rst_addr", 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
    check("rst_wdata", 64'(m_axi_wdata), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(1));

    // Single read.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    #1 check("rd_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk); req_valid = 1'b0; m_axi_arready = 1'b1; #1;
    check("rd_arvalid", 64'(m_axi_arvalid), 64'(1));
    check("rd_araddr", 64'(m_axi_araddr), 64'h100);
    @(negedge clk); m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 64'hDEADBEEF; m_axi_rresp = RESP_OKAY; rsp_ready = 1'b1; #1;
    check("rd_ar_drop", 64'(m_axi_arvalid), 64'(0));
    check("rd_rsp_valid", 64'(rsp_valid), 64'(1));
    check("rd_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    check("rd_err_we", 64'({rsp_err, rsp_we}), 64'(0));
    check("rd_rready", 64'(m_axi_rready), 64'(1));
    @(negedge clk); m_axi_rvalid = 1'b0; rsp_ready = 1'b0;

    // Split write: AW held off for three cycles while W is accepted at once.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h200; req_wdata = 64'hA5A5_0000_1234_5678;
    req_wstrb = 8'hFF; m_axi_wready = 1'b1; m_axi_awready = 1'b0;
    #1 check("wr_req_ready", 64'(req_ready), 64'(1));
    @(negedge clk); req_addr = 32'h204; req_wdata = 64'h0BAD_F00D_CAFE_0001; #1;
    check("wr_both_valid", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(3));
    check("wr_awaddr", 64'(m_axi_awaddr), 64'h200);
    check("wr_wdata", 64'(m_axi_wdata), 64'hA5A5_0000_1234_5678);
    check("wr_hold_ready0", 64'(req_ready), 64'(0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("wr_w_dropped", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(2));
      check("wr_hold_ready", 64'(req_ready), 64'(0));
    end
    @(negedge clk); m_axi_awready = 1'b1; #1;
    check("wr_aw_fire_ready", 64'(req_ready), 64'(1));
    @(negedge clk); req_valid = 1'b0; #1;
    check("wr2_valid", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(3));
    check("wr2_awaddr", 64'(m_axi_awaddr), 64'h204);
    @(negedge clk); m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = RESP_SLVERR; rsp_ready = 1'b1; #1;
    check("wr_aw_dropped", 64'(m_axi_awvalid), 64'(0));
    check("wr_rsp_valid", 64'(rsp_valid), 64'(1));
    check("wr_err_we", 64'({rsp_err, rsp_we}), 64'(3));
    check("wr_rdata_zero", 64'(rsp_rdata), 64'(0));
    check("wr_bready", 64'(m_axi_bready), 64'(1));
    @(negedge clk); m_axi_bresp = RESP_OKAY; #1;
    check("wr2_rsp", 64'({rsp_valid, rsp_err, rsp_we}), 64'(5));
    @(negedge clk); m_axi_bvalid = 1'b0; rsp_ready = 1'b0;

    // Depth limit: five back-to-back reads, no R returned.
    m_axi_arready = 1'b1; nacc = 0; nar = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300 + AW'(4 * nacc); #1;
      if (m_axi_arvalid) begin
        check("depth_araddr", 64'(m_axi_araddr), 64'(32'h300 + AW'(4 * nar)));
        nar++;
      end
      if (req_ready) nacc++;
    end
    check("depth_ar_fires", 64'(nar), 64'(4));
    check("depth_accepted", 64'(nacc), 64'(4));
    check("depth_ready_low", 64'(req_ready), 64'(0));
    @(negedge clk); m_axi_rvalid = 1'b1; m_axi_rdata = 64'h55; rsp_ready = 1'b1; #1;
    check("depth_rsp_same_cycle", 64'({rsp_valid, req_ready}), 64'(2));
    @(negedge clk); m_axi_rvalid = 1'b0; #1;
    check("depth_restore", 64'(req_ready), 64'(1));
    nrsp = 0;
    for (int c = 0; c < 20 && nrsp < 4; c++) begin
      @(negedge clk); req_valid = 1'b0; m_axi_rvalid = 1'b1; rsp_ready = 1'b1; #1;
      if (rsp_valid) nrsp++;
    end
    check("depth_drain", 64'(nrsp), 64'(4));
    @(negedge clk); m_axi_rvalid = 1'b0; rsp_ready = 1'b0;

    // Mode switch: two reads outstanding block a write.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; #1;
    check("sw_rd0", 64'(req_ready), 64'(1));
    @(negedge clk); req_addr = 32'h404; #1;
    check("sw_rd1", 64'(req_ready), 64'(1));
    @(negedge clk); req_we = 1'b1; req_addr = 32'h500; req_wdata = 64'h77; req_wstrb = 8'h0F; #1;
    check("sw_block0", 64'(req_ready), 64'(0));
    @(negedge clk); #1;
    check("sw_block1", 64'(req_ready), 64'(0));
    @(negedge clk); m_axi_rvalid = 1'b1; rsp_ready = 1'b1; #1;
    check("sw_block2", 64'({rsp_valid, req_ready}), 64'(2));
    @(negedge clk); #1;
    check("sw_block3", 64'({rsp_valid, req_ready}), 64'(2));
    @(negedge clk); m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; #1;
    check("sw_release", 64'(req_ready), 64'(1));
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b0; #1;
    check("sw_aw_w_valid", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(3));
    check("sw_awaddr", 64'(m_axi_awaddr), 64'h500);

    // Asynchronous reset in the middle of a write, between clock edges.
    #2 reset = 1'b1; #1;
    check("arst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}), 64'(0));
    @(negedge clk); reset = 1'b0;

    // Wide write; a write accepted right away also shows pend was cleared.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h700;
    req_wdata = 64'h1122334455667788; req_wstrb = 8'hF0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; #1;
    check("arst_pend_clear", 64'(req_ready), 64'(1));
    @(negedge clk); req_valid = 1'b0; #1;
    check("w64_wdata", 64'(m_axi_wdata), 64'h1122334455667788);
    check("w64_wstrb", 64'(m_axi_wstrb), 64'hF0);
    @(negedge clk); m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b1; m_axi_bresp = RESP_OKAY; rsp_ready = 1'b1; #1;
    check("w64_rsp", 64'({rsp_valid, rsp_err, rsp_we}), 64'(5));
    @(negedge clk); m_axi_bvalid = 1'b0; rsp_ready = 1'b0; #1;
`ifdef IXAYOI_AXIL_PERF_EN
    check("perf_txn", perf_txn, 64'(1));
    check("perf_stall", 64'(perf_stall), 64'(0));
`endif

    // Random traffic against the scoreboard.
    idle();
    m_pend = 0; m_acc = 0; m_dlv = 0; m_ar = 0; m_aw = 0; m_w = 0; m_b = 0;
    m_mode = 1'b1; cur_we = 1'b0; r_prev = 1'b0; b_prev = 1'b0; req_prev = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      gen = (cyc < 2500);
      if (!gen && m_pend == 0 && !req_valid) break;
      @(negedge clk);
      if (req_prev) req_valid = 1'b0;
      if (r_prev) m_axi_rvalid = 1'b0;
      if (b_prev) m_axi_bvalid = 1'b0;
      if (!req_valid && gen && $urandom_range(3) != 0) begin
        if ($urandom_range(7) == 0) cur_we = ~cur_we;
        req_valid = 1'b1; req_we = cur_we;
        req_addr = AW'($urandom()) & ~AW'(7);
        req_wdata = {32'($urandom()), 32'($urandom())};
        req_wstrb = SW'($urandom());
      end
      m_axi_arready = 1'($urandom_range(1));
      m_axi_awready = 1'($urandom_range(1));
      m_axi_wready  = 1'($urandom_range(1));
      rsp_ready     = ($urandom_range(3) != 0);
      if (!m_axi_rvalid && r_q.size() > 0 && $urandom_range(2) != 0) begin
        m_axi_rvalid = 1'b1; m_axi_rdata = r_q[0].data; m_axi_rresp = r_q[0].resp;
      end
      if (!m_axi_bvalid && b_q.size() > 0 && $urandom_range(2) != 0) begin
        m_axi_bvalid = 1'b1; m_axi_bresp = b_q[0];
      end
      #1;
      ar_f  = m_axi_arvalid & m_axi_arready;
      aw_f  = m_axi_awvalid & m_axi_awready;
      w_f   = m_axi_wvalid & m_axi_wready;
      r_f   = m_axi_rvalid & m_axi_rready;
      b_f   = m_axi_bvalid & m_axi_bready;
      req_f = req_valid & req_ready;
      rsp_f = rsp_valid & rsp_ready;
      issued = m_ar + ((m_aw < m_w) ? m_aw : m_w) - m_dlv;
      done_after = m_ar + int'(ar_f)
                 + (((m_aw + int'(aw_f)) < (m_w + int'(w_f))) ? (m_aw + int'(aw_f)) : (m_w + int'(w_f)));
      if (req_valid) begin
        exp_rdy = (m_acc == done_after) && (m_pend < int'(MO)) && (m_pend == 0 || req_we == m_mode);
        check("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
      end
      check("rnd_rsp_valid", 64'(rsp_valid),
            64'((issued > 0) && (m_mode ? m_axi_bvalid : m_axi_rvalid)));
      check("rnd_rready", 64'(m_axi_rready), 64'(rsp_ready && !m_mode && issued > 0));
      check("rnd_bready", 64'(m_axi_bready), 64'(rsp_ready && m_mode && issued > 0));
      if (ar_f) begin
        if (exp_ar_q.size() == 0) check("rnd_ar_spurious", 64'(1), 64'(0));
        else begin
          rd_e = exp_ar_q.pop_front();
          check("rnd_araddr", 64'(m_axi_araddr), 64'(rd_e.addr));
          r_q.push_back(rd_e);
        end
        m_ar++;
      end
      if (aw_f) begin
        if (exp_aw_q.size() == 0) check("rnd_aw_spurious", 64'(1), 64'(0));
        else check("rnd_awaddr", 64'(m_axi_awaddr), 64'(exp_aw_q.pop_front()));
        m_aw++;
      end
      if (w_f) begin
        if (exp_w_q.size() == 0) check("rnd_w_spurious", 64'(1), 64'(0));
        else begin
          wd_e = exp_w_q.pop_front();
          check("rnd_wdata", m_axi_wdata, wd_e.data);
          check("rnd_wstrb", 64'(m_axi_wstrb), 64'(wd_e.strb));
        end
        m_w++;
      end
      while (m_b < m_aw && m_b < m_w && wr_resp_q.size() > 0) begin
        b_q.push_back(wr_resp_q.pop_front());
        m_b++;
      end
      if (r_f && r_q.size() > 0) void'(r_q.pop_front());
      if (b_f && b_q.size() > 0) void'(b_q.pop_front());
      if (rsp_f) begin
        if (exp_rsp_q.size() == 0) check("rnd_rsp_spurious", 64'(1), 64'(0));
        else begin
          rs_e = exp_rsp_q.pop_front();
          check("rnd_rsp_we", 64'(rsp_we), 64'(rs_e.we));
          check("rnd_rsp_err", 64'(rsp_err), 64'(rs_e.err));
          check("rnd_rsp_rdata", rsp_rdata, rs_e.data);
        end
        m_dlv++;
      end
      if (req_f) begin
        if (m_pend == 0) m_mode = req_we;
        m_acc++;
        rresp_n = 2'($urandom_range(3));
        rdata_n = {32'($urandom()), 32'($urandom())};
        if (req_we) begin
          exp_aw_q.push_back(req_addr);
          exp_w_q.push_back({req_wdata, req_wstrb});
          wr_resp_q.push_back(rresp_n);
          exp_rsp_q.push_back({1'b1, rresp_n[1], 64'(0)});
        end else begin
          exp_ar_q.push_back({req_addr, rresp_n, rdata_n});
          exp_rsp_q.push_back({1'b0, rresp_n[1], rdata_n});
        end
      end
      m_pend = m_pend + int'(req_f) - int'(rsp_f);
      req_prev = req_f; r_prev = r_f; b_prev = b_f;
    end
    check("rnd_drain_pend", 64'(m_pend), 64'(0));
    check("rnd_drain_queue", 64'(exp_rsp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
